spart_baud_ctrl: RTL and testbench
==================================

SPART_BAUD_CTRL -- requirements
Module: spart_baud_ctrl

Interface
REQ-001 The block SHALL have port clk, input, 1, system clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 The block SHALL have port br_cfg, input, 2, baud select: 00=4800, 01=9600, 10=19200, 11=38400.
REQ-004 The block SHALL have port cfg_req, input, 1, reprogram request; a single-cycle pulse is sufficient.
REQ-005 The block SHALL have port tx_busy, input, 1, transmitter mid-frame.
REQ-006 The block SHALL have port rx_busy, input, 1, receiver mid-frame.
REQ-007 The block SHALL have port brg_ready, input, 1, baud generator has both divisor bytes loaded.
REQ-008 The block SHALL have ports cpu_wr (input, 1), cpu_addr (input, 2) and cpu_data (input, 8), the processor divisor-write port.
REQ-009 The block SHALL have port brg_data, output, 8, divisor byte to the baud generator.
REQ-010 The block SHALL have ports brg_load_low and brg_load_high, output, 1 each, load strobes to the baud generator.
REQ-011 The block SHALL have ports cfg_busy (output, 1), cfg_done (output, 1, one-cycle pulse), cur_baud (output, 2) and cpu_stall (output, 1).

Function
REQ-012 Divisor table SHALL be 00->0x0516, 01->0x028B, 10->0x0145, 11->0x00A3.
REQ-013 FSM states SHALL be IDLE, WAIT_IDLE, LOAD_LO, LOAD_HI, WAIT_RDY and DONE; the state register is registered, and strobes are decoded from state.
REQ-014 A pending flag SHALL set when cfg_req=1, and sel_q SHALL capture br_cfg at that edge; a later request overwrites sel_q while still pending.
REQ-015 IDLE with pending=1 and no IDLE cpu write granted that cycle SHALL go to WAIT_IDLE and clear pending.
REQ-016 WAIT_IDLE SHALL go to LOAD_LO on the first cycle with tx_busy=0 and rx_busy=0; otherwise it SHALL hold.
REQ-017 LOAD_LO SHALL assert brg_load_low=1 with brg_data=table[sel_q][7:0] for exactly one cycle, then go to LOAD_HI.
REQ-018 LOAD_HI SHALL assert brg_load_high=1 with brg_data=table[sel_q][15:8] for exactly one cycle, then go to WAIT_RDY.
REQ-019 WAIT_RDY SHALL go to DONE when brg_ready=1.
REQ-020 DONE SHALL pulse cfg_done=1 for one cycle, update cur_baud<=sel_q, and return to IDLE.
REQ-021 Latency: with cfg_req at cycle 0, busy inputs low and brg_ready=1, brg_load_low SHALL be high at cycle 2, brg_load_high at cycle 3, and cfg_done at cycle 5.
REQ-022 cfg_busy SHALL be 1 in every state except IDLE, and also whenever pending=1.
REQ-023 A cfg_req arriving while not IDLE SHALL be latched and serviced after DONE; at most one request is held pending.
REQ-024 tx_busy or rx_busy asserting after WAIT_IDLE SHALL be ignored; the load sequence completes.
REQ-025 In IDLE, cpu_wr with cpu_addr=10 SHALL combinationally drive brg_load_low=1 and brg_data=cpu_data; cpu_addr=11 SHALL do the same on brg_load_high.
REQ-026 An IDLE cpu write SHALL win over a same-cycle cfg_req or pending flag; the request stays pending to the next cycle.
REQ-027 cpu_wr with cpu_addr[1]=1 outside IDLE SHALL set cpu_stall=1 combinationally and cause no load; the CPU holds the write.
REQ-028 cpu_addr 00/01 SHALL be ignored, with no stall.
REQ-029 brg_data SHALL be 0x00 whenever neither strobe is asserted.

Reset
REQ-030 On rst=1 the block SHALL set state=IDLE, pending=0, sel_q=01 and cur_baud=01, and all strobes, cfg_busy, cfg_done and cpu_stall SHALL be 0 from the next cycle.
REQ-031 rst mid-sequence SHALL abort the sequence with no further load strobes; the baud generator retains its own reset divisor 0x028B, consistent with cur_baud=01.

Configuration
REQ-032 Macro SPART_BAUD_CPU_EN defined SHALL compile in the cpu write path (REQ-025..REQ-028).
REQ-033 With SPART_BAUD_CPU_EN undefined, the cpu_* inputs SHALL be ignored, cpu_stall SHALL be tied 0, and strobes SHALL come only from the FSM.

Verification
REQ-034 The bench SHALL cover: reset, then cfg_req with br_cfg=00 and busy low -> brg_load_low with 0x16 at cycle 2, brg_load_high with 0x05 at cycle 3, cfg_done at cycle 5, cur_baud=00.
REQ-035 The bench SHALL cover: tx_busy=1 for 10 cycles after cfg_req with br_cfg=11 -> held in WAIT_IDLE, LOAD_LO 1 cycle after tx_busy falls with data 0xA3, then 0x00.
REQ-036 The bench SHALL cover: cfg_req br_cfg=10 during an active sequence -> first sequence completes, then second loads 0x45/0x01, giving two cfg_done pulses and cur_baud=10.
REQ-037 The bench SHALL cover: same-cycle cpu_wr addr=10 data=0x55 and cfg_req in IDLE -> brg_load_low with 0x55 that cycle, FSM leaves IDLE next cycle; cpu_wr addr=11 during LOAD_HI -> cpu_stall=1, no extra strobe.
REQ-038 The bench SHALL cover: rst asserted in LOAD_LO -> no brg_load_high, IDLE, cur_baud=01, cfg_busy=0.
REQ-039 The bench SHALL cover: the build without SPART_BAUD_CPU_EN -> cpu_wr addr=10 in IDLE produces no strobe and cpu_stall=0.

Source files
------------

// File: rtl/spart_baud_ctrl.sv
// spart_baud_ctrl: sequences divisor reloads into the SPART baud generator.
// A configuration request selects one of four baud divisors. The request is
// serviced once both transmitter and receiver are between frames. The two
// divisor bytes are then strobed into the generator, low byte first.
// Optional feature: define SPART_BAUD_CPU_EN to compile in the direct
// processor divisor-write path (cpu_wr / cpu_addr / cpu_data, cpu_stall).
module spart_baud_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] br_cfg,
   input  logic       cfg_req,
   input  logic       tx_busy,
   input  logic       rx_busy,
   input  logic       brg_ready,
   input  logic       cpu_wr,
   input  logic [1:0] cpu_addr,
   input  logic [7:0] cpu_data,
   output logic [7:0] brg_data,
   output logic       brg_load_low,
   output logic       brg_load_high,
   output logic       cfg_busy,
   output logic       cfg_done,
   output logic [1:0] cur_baud,
   output logic       cpu_stall
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_IDLE,
      LOAD_LO,
      LOAD_HI,
      WAIT_RDY,
      DONE
   } state_t;

   state_t      state;
   logic        pending;
   logic [1:0]  pend_sel;   // selection of the single request held pending
   logic [1:0]  sel_q;      // selection of the sequence in flight
   logic [15:0] div_sel;
   logic        cpu_grant;
   logic        cpu_lo;
   logic        cpu_hi;

`ifdef SPART_BAUD_CPU_EN
   logic cpu_hit;
   // Only addresses 10/11 target the divisor; 00/01 are ignored entirely.
   assign cpu_hit   = cpu_wr & cpu_addr[1];
   assign cpu_grant = cpu_hit & (state == IDLE);
   assign cpu_lo    = cpu_grant & ~cpu_addr[0];
   assign cpu_hi    = cpu_grant &  cpu_addr[0];
   // Outside IDLE the FSM owns the strobes, so the CPU must hold its write.
   assign cpu_stall = cpu_hit & (state != IDLE);
`else
   logic unused_cpu;
   assign unused_cpu = ^{cpu_wr, cpu_addr};
   assign cpu_grant  = 1'b0;
   assign cpu_lo     = 1'b0;
   assign cpu_hi     = 1'b0;
   assign cpu_stall  = 1'b0;
`endif

   // Divisor lookup for the selection currently being loaded.
   always_comb begin
      case (sel_q)
         2'b00:   div_sel = 16'h0516;
         2'b01:   div_sel = 16'h028B;
         2'b10:   div_sel = 16'h0145;
         default: div_sel = 16'h00A3;
      endcase
   end

   // Strobes and data bus decoded from state, or from a granted CPU write in IDLE.
   always_comb begin
      brg_load_low  = (state == LOAD_LO) | cpu_lo;
      brg_load_high = (state == LOAD_HI) | cpu_hi;
      if (state == LOAD_LO)
         brg_data = div_sel[7:0];
      else if (state == LOAD_HI)
         brg_data = div_sel[15:8];
      else if (cpu_grant)
         brg_data = cpu_data;
      else
         brg_data = 8'h00;
   end

   assign cfg_busy = (state != IDLE) | pending;
   assign cfg_done = (state == DONE);

   // Reload sequencer with a one-deep pending-request latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pending  <= 1'b0;
         pend_sel <= 2'b01;
         sel_q    <= 2'b01;
         cur_baud <= 2'b01;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_grant) begin
                  // CPU write owns this cycle; keep any request for the next one.
                  if (cfg_req) begin
                     pending  <= 1'b1;
                     pend_sel <= br_cfg;
                  end
               end else if (cfg_req || pending) begin
                  sel_q   <= cfg_req ? br_cfg : pend_sel;
                  pending <= 1'b0;
                  state   <= WAIT_IDLE;
               end
            end
            WAIT_IDLE: if (!tx_busy && !rx_busy) state <= LOAD_LO;
            LOAD_LO:   state <= LOAD_HI;
            LOAD_HI:   state <= WAIT_RDY;
            WAIT_RDY:  if (brg_ready) state <= DONE;
            DONE: begin
               cur_baud <= sel_q;
               state    <= IDLE;
            end
            default:   state <= IDLE;
         endcase
         // Requests arriving mid-sequence are held; the latest one wins.
         if (state != IDLE && cfg_req) begin
            pending  <= 1'b1;
            pend_sel <= br_cfg;
         end
      end
   end

endmodule

// File: tb/tb_spart_baud_ctrl.sv
// tb_spart_baud_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a transaction-level reference model of the reload protocol.
module tb_spart_baud_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] br_cfg;
   logic       cfg_req;
   logic       tx_busy;
   logic       rx_busy;
   logic       brg_ready;
   logic       cpu_wr;
   logic [1:0] cpu_addr;
   logic [7:0] cpu_data;
   logic [7:0] brg_data;
   logic       brg_load_low;
   logic       brg_load_high;
   logic       cfg_busy;
   logic       cfg_done;
   logic [1:0] cur_baud;
   logic       cpu_stall;

`ifdef SPART_BAUD_CPU_EN
   localparam bit CPU_EN = 1'b1;
`else
   localparam bit CPU_EN = 1'b0;
`endif

   spart_baud_ctrl dut (
      .clk(clk), .rst(rst), .br_cfg(br_cfg), .cfg_req(cfg_req),
      .tx_busy(tx_busy), .rx_busy(rx_busy), .brg_ready(brg_ready),
      .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
      .brg_data(brg_data), .brg_load_low(brg_load_low),
      .brg_load_high(brg_load_high), .cfg_busy(cfg_busy),
      .cfg_done(cfg_done), .cur_baud(cur_baud), .cpu_stall(cpu_stall)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
   endtask

   // Reference model: a request becomes a job; a job walks through numbered
   // phases (0 wait for quiet link, 1 low byte, 2 high byte, 3 wait ready,
   // 4 complete). active_job=0 means the controller is free.
   int unsigned divisor [4] = '{16'h0516, 16'h028B, 16'h0145, 16'h00A3};
   bit          active_job;
   int          phase;
   int          job_sel;
   bit          has_queued;
   int          queued_sel;
   int          baud_now;

   // Sampled DUT outputs of the most recent cycle, for directed checks.
   logic       c_lo, c_hi, c_busy, c_done, c_stall;
   logic [7:0] c_data;
   logic [1:0] c_baud;

   task automatic model_reset();
      active_job = 0; phase = 0; job_sel = 1;
      has_queued = 0; queued_sel = 1; baud_now = 1;
   endtask

   // One clock cycle: compare outputs at negedge, advance the model at posedge.
   task automatic tick();
      bit         cpu_go, e_lo, e_hi, e_stall, e_busy, e_done;
      int         e_data;
      @(negedge clk);
      cpu_go  = CPU_EN && cpu_wr && cpu_addr[1];
      e_lo    = (active_job && phase == 1) || (!active_job && cpu_go && !cpu_addr[0]);
      e_hi    = (active_job && phase == 2) || (!active_job && cpu_go &&  cpu_addr[0]);
      if (active_job && phase == 1)      e_data = divisor[job_sel] % 256;
      else if (active_job && phase == 2) e_data = divisor[job_sel] / 256;
      else if (!active_job && cpu_go)    e_data = cpu_data;
      else                               e_data = 0;
      e_stall = cpu_go && active_job;
      e_busy  = active_job || has_queued;
      e_done  = active_job && phase == 4;
      check("brg_load_low",  16'(brg_load_low),  16'(e_lo));
      check("brg_load_high", 16'(brg_load_high), 16'(e_hi));
      check("brg_data",      16'(brg_data),      16'(e_data));
      check("cpu_stall",     16'(cpu_stall),     16'(e_stall));
      check("cfg_busy",      16'(cfg_busy),      16'(e_busy));
      check("cfg_done",      16'(cfg_done),      16'(e_done));
      check("cur_baud",      16'(cur_baud),      16'(baud_now));
      c_lo = brg_load_low; c_hi = brg_load_high; c_data = brg_data;
      c_busy = cfg_busy; c_done = cfg_done; c_baud = cur_baud; c_stall = cpu_stall;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else if (!active_job) begin
         if (cpu_go) begin
            if (cfg_req) begin has_queued = 1; queued_sel = br_cfg; end
         end else if (cfg_req || has_queued) begin
            job_sel    = cfg_req ? int'(br_cfg) : queued_sel;
            has_queued = 0;
            active_job = 1;
            phase      = 0;
         end
      end else begin
         if (cfg_req) begin has_queued = 1; queued_sel = br_cfg; end
         case (phase)
            0: if (!tx_busy && !rx_busy) phase = 1;
            1, 2: phase++;
            3: if (brg_ready) phase = 4;
            default: begin baud_now = job_sel; active_job = 0; end
         endcase
      end
      #1;
   endtask

   task automatic quiet_inputs();
      rst = 0; cfg_req = 0; br_cfg = 0; tx_busy = 0; rx_busy = 0;
      brg_ready = 1; cpu_wr = 0; cpu_addr = 0; cpu_data = 0;
   endtask

   int dones;

   initial begin
      quiet_inputs();
      model_reset();
      rst = 1;
      #1;
      repeat (2) tick();
      rst = 0;
      tick();
      check("reset_busy", 16'(c_busy), 16'd0);
      check("reset_baud", 16'(c_baud), 16'd1);

      // Request 4800 with an idle link: low at 2, high at 3, done at 5.
      for (int k = 0; k < 8; k++) begin
         cfg_req = (k == 0); br_cfg = 2'b00;
         tick();
         if (k == 2) begin check("s1_lo", 16'(c_lo), 16'd1); check("s1_lo_data", 16'(c_data), 16'h16); end
         if (k == 3) begin check("s1_hi", 16'(c_hi), 16'd1); check("s1_hi_data", 16'(c_data), 16'h05); end
         if (k == 5) check("s1_done", 16'(c_done), 16'd1);
      end
      check("s1_baud", 16'(cur_baud), 16'd0);

      // Transmitter busy for 10 cycles holds the sequence before loading.
      for (int k = 0; k < 16; k++) begin
         cfg_req = (k == 0); br_cfg = 2'b11; tx_busy = (k < 10);
         tick();
         if (k == 6)  check("s2_hold", 16'(c_lo), 16'd0);
         if (k == 11) begin check("s2_lo", 16'(c_lo), 16'd1); check("s2_lo_data", 16'(c_data), 16'hA3); end
         if (k == 12) check("s2_hi_data", 16'(c_data), 16'h00);
      end
      tx_busy = 0;

      // Second request during an active sequence is serviced afterwards.
      dones = 0;
      for (int k = 0; k < 15; k++) begin
         cfg_req = (k == 0 || k == 3); br_cfg = (k == 0) ? 2'b00 : 2'b10;
         tick();
         dones += int'(c_done);
         if (k == 3) check("s3_first_hi", 16'(c_data), 16'h05);
         if (k == 8) check("s3_second_lo", 16'(c_data), 16'h45);
         if (k == 9) check("s3_second_hi", 16'(c_data), 16'h01);
      end
      check("s3_dones", 16'(dones), 16'd2);
      check("s3_baud", 16'(cur_baud), 16'd2);

`ifdef SPART_BAUD_CPU_EN
      // CPU write wins over a same-cycle request; stall during LOAD_HI.
      for (int k = 0; k < 8; k++) begin
         cfg_req = (k == 0); br_cfg = 2'b01;
         cpu_wr = (k == 0 || k == 4);
         cpu_addr = (k == 0) ? 2'b10 : 2'b11;
         cpu_data = (k == 0) ? 8'h55 : 8'hAA;
         tick();
         if (k == 0) begin check("s4_cpu_lo", 16'(c_lo), 16'd1); check("s4_cpu_data", 16'(c_data), 16'h55); end
         if (k == 1) check("s4_pending_busy", 16'(c_busy), 16'd1);
         if (k == 3) check("s4_fsm_lo_data", 16'(c_data), 16'h8B);
         if (k == 4) begin check("s4_stall", 16'(c_stall), 16'd1); check("s4_hi_data", 16'(c_data), 16'h02); end
      end
      cpu_wr = 0;
`else
      // Without the CPU path a divisor write is ignored.
      cpu_wr = 1; cpu_addr = 2'b10; cpu_data = 8'h55;
      tick();
      check("s6_no_lo", 16'(c_lo), 16'd0);
      check("s6_no_stall", 16'(c_stall), 16'd0);
      check("s6_data", 16'(c_data), 16'h00);
      cpu_wr = 0;
      tick();
`endif

      // Reset during LOAD_LO aborts the sequence.
      for (int k = 0; k < 7; k++) begin
         cfg_req = (k == 0); br_cfg = 2'b11; rst = (k == 2);
         tick();
         if (k == 2) check("s5_in_lo", 16'(c_lo), 16'd1);
         if (k >= 3) check("s5_no_hi", 16'(c_hi), 16'd0);
         if (k == 3) begin check("s5_busy", 16'(c_busy), 16'd0); check("s5_baud", 16'(c_baud), 16'd1); end
      end

      // Randomized traffic against the model.
      for (int k = 0; k < 3000; k++) begin
         rst       = ($urandom_range(0, 199) == 0);
         cfg_req   = ($urandom_range(0, 11) == 0);
         br_cfg    = 2'($urandom);
         tx_busy   = ($urandom_range(0, 3) == 0);
         rx_busy   = ($urandom_range(0, 4) == 0);
         brg_ready = ($urandom_range(0, 3) != 0);
         cpu_wr    = ($urandom_range(0, 3) == 0);
         cpu_addr  = 2'($urandom);
         cpu_data  = 8'($urandom);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
